multicycle_data_path: RTL and testbench

Parametrised multicycle RV32I-subset datapath with integrated control FSM and a single stalling memory port. It is the successor to the single-cycle `data_path`, and generalises register width (XLEN) and register count (NREGS, so RV32E fits). It adds memory wait-state handling, illegal-instruction halting and a retire strobe. It sits between the instruction/data memory (or bus adapter) and the top-level core wrapper.

---
 rtl/multicycle_data_path.sv | 305 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_data_path.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_data_path.sv
// Multicycle RV32I-subset datapath with control FSM and one stalling memory port.
// Fetch, load and store share the port; an illegal or misaligned operation halts until reset.
module multicycle_data_path #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     mem_valid,
  output logic                     mem_we,
  output logic [XLEN-1:0]          mem_addr,
  output logic [31:0]              mem_wdata,
  input  logic [31:0]              mem_rdata,
  input  logic                     mem_ready,
  output logic [XLEN-1:0]          pc,
  output logic                     retire,
  output logic                     illegal,
  input  logic [$clog2(NREGS)-1:0] dbg_raddr,
  output logic [XLEN-1:0]          dbg_rdata
);

  localparam int unsigned RW = $clog2(NREGS);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_EXEC_R   = 4'd2;
  localparam logic [3:0] S_EXEC_I   = 4'd3;
  localparam logic [3:0] S_ALUWB    = 4'd4;
  localparam logic [3:0] S_MEMADR   = 4'd5;
  localparam logic [3:0] S_MEMREAD  = 4'd6;
  localparam logic [3:0] S_MEMWB    = 4'd7;
  localparam logic [3:0] S_MEMWRITE = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_HALT     = 4'd11;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [3:0]      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [XLEN-1:0] oldpc_q, oldpc_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] target_q, target_d;
  logic [XLEN-1:0] aluout_q, aluout_d;
  logic [XLEN-1:0] mdr_q, mdr_d;
  logic            mem_valid_q, mem_valid_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]     mem_wdata_q, mem_wdata_d;
  logic            illegal_q, illegal_d;
  logic            retire_c;

  logic [XLEN-1:0] rf_q [NREGS];
  logic            rf_we_c;
  logic [RW-1:0]   rf_wa_c;
  logic [XLEN-1:0] rf_wd_c;

  // Instruction fields and sign-extended immediates
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i32, imm_s32, imm_b32, imm_j32;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j;

  assign opcode  = instr_q[6:0];
  assign rd      = instr_q[11:7];
  assign funct3  = instr_q[14:12];
  assign rs1     = instr_q[19:15];
  assign rs2     = instr_q[24:20];
  assign funct7  = instr_q[31:25];
  assign imm_i32 = {{20{instr_q[31]}}, instr_q[31:20]};
  assign imm_s32 = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
  assign imm_b32 = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0};
  assign imm_j32 = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21], 1'b0};
  assign imm_i   = XLEN'($signed(imm_i32));
  assign imm_s   = XLEN'($signed(imm_s32));
  assign imm_b   = XLEN'($signed(imm_b32));
  assign imm_j   = XLEN'($signed(imm_j32));

  // Decode: only fields an instruction actually uses are range-checked against NREGS
  logic rd_ok, rs1_ok, rs2_ok;
  logic dec_r, dec_i, dec_lw, dec_sw, dec_beq, dec_jal;
  logic r_fn_ok, i_fn_ok;

  assign rd_ok  = 32'(rd) < NREGS;
  assign rs1_ok = 32'(rs1) < NREGS;
  assign rs2_ok = 32'(rs2) < NREGS;

  always_comb begin
    r_fn_ok = 1'b0;
    i_fn_ok = 1'b0;
    unique case (funct3)
      3'b000, 3'b010, 3'b110, 3'b111: i_fn_ok = 1'b1;
      default:                        i_fn_ok = 1'b0;
    endcase
    if (funct7 == 7'h00) begin
      r_fn_ok = i_fn_ok;
    end else if (funct7 == 7'h20) begin
      r_fn_ok = (funct3 == 3'b000);
    end
  end

  assign dec_r   = (opcode == OP_R) && r_fn_ok && rd_ok && rs1_ok && rs2_ok;
  assign dec_i   = (opcode == OP_I) && i_fn_ok && rd_ok && rs1_ok;
  assign dec_lw  = (opcode == OP_LOAD) && (funct3 == 3'b010) && rd_ok && rs1_ok;
  assign dec_sw  = (opcode == OP_STORE) && (funct3 == 3'b010) && rs1_ok && rs2_ok;
  assign dec_beq = (opcode == OP_BRANCH) && (funct3 == 3'b000) && rs1_ok && rs2_ok;
  assign dec_jal = (opcode == OP_JAL) && rd_ok;

  logic [XLEN-1:0] rs1_val, rs2_val;
  assign rs1_val = rf_q[rs1[RW-1:0]];
  assign rs2_val = rf_q[rs2[RW-1:0]];

  // ALU shared by R-type and I-type; funct3 encodings coincide for both
  logic [XLEN-1:0] alu_b, alu_res;
  logic            alu_sub;

  assign alu_b   = (state_q == S_EXEC_R) ? b_q : imm_i;
  assign alu_sub = (state_q == S_EXEC_R) && funct7[5];

  always_comb begin
    alu_res = a_q + alu_b;
    unique case (funct3)
      3'b000:  alu_res = alu_sub ? (a_q - alu_b) : (a_q + alu_b);
      3'b010:  alu_res = XLEN'($signed(a_q) < $signed(alu_b));
      3'b110:  alu_res = a_q | alu_b;
      3'b111:  alu_res = a_q & alu_b;
      default: alu_res = a_q + alu_b;
    endcase
  end

  logic [XLEN-1:0] eff_addr;
  logic            mem_done;

  assign eff_addr = a_q + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign mem_done = mem_valid_q && mem_ready;

  // Next-state, datapath latches, register write and retire strobe
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    oldpc_d  = oldpc_q;
    a_d      = a_q;
    b_d      = b_q;
    target_d = target_q;
    aluout_d = aluout_q;
    mdr_d    = mdr_q;
    rf_we_c  = 1'b0;
    rf_wa_c  = rd[RW-1:0];
    rf_wd_c  = '0;
    retire_c = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        if (mem_done) begin
          instr_d = mem_rdata;
          oldpc_d = pc_q;
          pc_d    = pc_q + XLEN'(4);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d      = rs1_val;
        b_d      = rs2_val;
        target_d = oldpc_q + ((opcode == OP_JAL) ? imm_j : imm_b);
        if (dec_r)                 state_d = S_EXEC_R;
        else if (dec_i)            state_d = S_EXEC_I;
        else if (dec_lw || dec_sw) state_d = S_MEMADR;
        else if (dec_beq)          state_d = S_BEQ;
        else if (dec_jal)          state_d = S_JAL;
        else                       state_d = S_HALT;
      end
      S_EXEC_R, S_EXEC_I: begin
        aluout_d = alu_res;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        rf_we_c  = 1'b1;
        rf_wd_c  = aluout_q;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMADR: begin
        aluout_d = eff_addr;
        if (eff_addr[1:0] != 2'b00)  state_d = S_HALT;
        else if (opcode == OP_STORE) state_d = S_MEMWRITE;
        else                         state_d = S_MEMREAD;
      end
      S_MEMREAD: begin
        if (mem_done) begin
          mdr_d   = XLEN'($signed(mem_rdata));
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we_c  = 1'b1;
        rf_wd_c  = mdr_q;
        retire_c = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEMWRITE: begin
        if (mem_done) begin
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_BEQ: begin
        if (a_q == b_q && target_q[1:0] != 2'b00) begin
          state_d = S_HALT;
        end else begin
          if (a_q == b_q) pc_d = target_q;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_JAL: begin
        if (target_q[1:0] != 2'b00) begin
          state_d = S_HALT;
        end else begin
          rf_we_c  = 1'b1;
          rf_wd_c  = oldpc_q + XLEN'(4);
          pc_d     = target_q;
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_HALT;
    endcase

    // Port outputs are registered from the upcoming state so they hold steady through wait states
    mem_valid_d = (state_d == S_FETCH) || (state_d == S_MEMREAD) || (state_d == S_MEMWRITE);
    mem_we_d    = (state_d == S_MEMWRITE);
    mem_addr_d  = (state_d == S_FETCH) ? pc_d : aluout_d;
    mem_wdata_d = b_q[31:0];
    illegal_d   = (state_d == S_HALT);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      instr_q     <= '0;
      oldpc_q     <= '0;
      a_q         <= '0;
      b_q         <= '0;
      target_q    <= '0;
      aluout_q    <= '0;
      mdr_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= RESET_PC;
      mem_wdata_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_q     <= instr_d;
      oldpc_q     <= oldpc_d;
      a_q         <= a_d;
      b_q         <= b_d;
      target_q    <= target_d;
      aluout_q    <= aluout_d;
      mdr_q       <= mdr_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      illegal_q   <= illegal_d;
    end
  end

  // Register file; x0 is never written so it reads as zero
  always_ff @(posedge clk) begin
    if (!reset) begin
      rf_q <= '{default: '0};
    end else if (rf_we_c && rf_wa_c != '0) begin
      rf_q[rf_wa_c] <= rf_wd_c;
    end
  end

  always_comb begin
    dbg_rdata = '0;
    if (dbg_raddr != '0) dbg_rdata = rf_q[dbg_raddr];
  end

  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign pc        = pc_q;
  assign retire    = retire_c;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_multicycle_data_path.sv
// Bench for multicycle_data_path (XLEN=32, NREGS=16): directed programs, retire/store scoreboard.
module tb_multicycle_data_path;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid, mem_we, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [31:0] pc, dbg_rdata;
  logic        retire, illegal;
  logic [3:0]  dbg_raddr = '0;

  multicycle_data_path #(.XLEN(32), .NREGS(16), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .retire(retire), .illegal(illegal),
    .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_rdata)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc = 0;
  int unsigned wcnt = 0;
  int unsigned wait_n = 0;

  logic [31:0] img [64];
  logic [31:0] wdat [64];
  logic [63:0] wr_valid = '0;

  typedef struct packed { logic [31:0] cyc; logic [31:0] pc; } ret_t;
  typedef struct packed { logic [31:0] addr; logic [31:0] data; } st_t;
  ret_t ret_q[$];
  st_t  st_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory side effects and cycle counter (cycle 1 = first cycle after reset release)
  always @(posedge clk) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
    if (!reset) wr_valid <= '0;
    if (mem_valid && mem_ready) begin
      if (mem_we) begin
        wdat[mem_addr[7:2]]     <= mem_wdata;
        wr_valid[mem_addr[7:2]] <= 1'b1;
      end
      wcnt <= 0;
    end else if (mem_valid) begin
      wcnt <= wcnt + 1;
    end else begin
      wcnt <= 0;
    end
  end

  // Memory responder: ready after wait_n stalled cycles
  always @(negedge clk) begin
    mem_ready = mem_valid && (wcnt >= wait_n);
    mem_rdata = wr_valid[mem_addr[7:2]] ? wdat[mem_addr[7:2]] : img[mem_addr[7:2]];
  end

  // Monitor: retire timing, pc after retire, stores, request stability
  logic        pc_pend = 1'b0;
  logic [31:0] pend_pc = '0;
  logic        hold_prev = 1'b0;
  logic [31:0] h_addr = '0, h_wdata = '0;
  logic        h_we = 1'b0;

  always @(negedge clk) begin
    ret_t e;
    st_t  s;
    #2;
    if (pc_pend) begin
      check("pc_after_retire", pc, pend_pc);
      pc_pend = 1'b0;
    end
    if (retire === 1'b1) begin
      if (ret_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_retire: retire at cycle %0d, none expected", cyc);
      end else begin
        e = ret_q.pop_front();
        check("retire_cycle", cyc, e.cyc);
        pend_pc = e.pc;
        pc_pend = 1'b1;
      end
    end
    if (mem_valid === 1'b1) check("req_aligned", 32'(mem_addr[1:0]), 32'h0);
    if (mem_valid === 1'b1 && mem_we === 1'b1 && mem_ready === 1'b1) begin
      if (st_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_store: addr 0x%08h data 0x%08h", mem_addr, mem_wdata);
      end else begin
        s = st_q.pop_front();
        check("store_addr", mem_addr, s.addr);
        check("store_data", mem_wdata, s.data);
      end
    end
    if (hold_prev && mem_valid === 1'b1) begin
      check("hold_addr", mem_addr, h_addr);
      check("hold_we", 32'(mem_we), 32'(h_we));
      if (h_we) check("hold_wdata", mem_wdata, h_wdata);
    end
    hold_prev = (mem_valid === 1'b1) && (mem_ready !== 1'b1);
    h_addr  = mem_addr;
    h_we    = mem_we;
    h_wdata = mem_wdata;
  end

  task automatic exp_ret(input int unsigned c, input logic [31:0] p);
    ret_q.push_back('{cyc: 32'(c), pc: p});
  endtask

  task automatic read_reg(input string name, input logic [3:0] idx, input logic [31:0] exp);
    dbg_raddr = idx;
    #1;
    check(name, dbg_rdata, exp);
  endtask

  task automatic clear_img();
    for (int i = 0; i < 64; i++) img[i] = 32'h0;
  endtask

  // Hold reset, check reset state, release; leaves us in cycle 1 after checking the first fetch
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("rst_mem_valid", 32'(mem_valid), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_retire", 32'(retire), 32'h0);
    check("rst_illegal", 32'(illegal), 32'h0);
    check("rst_pc", pc, 32'h0);
    read_reg("rst_x1", 4'd1, 32'h0);
    reset = 1'b1;
    @(negedge clk);
    #2;
    check("first_fetch_valid", 32'(mem_valid), 32'h1);
    check("first_fetch_addr", mem_addr, 32'h0);
  endtask

  task automatic run_until_halt(input int unsigned budget);
    int unsigned n = 0;
    while (illegal !== 1'b1 && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (illegal !== 1'b1) begin
      checks++; errors++;
      $display("FAIL halt_timeout: no halt within %0d cycles", budget);
    end
    repeat (2) @(negedge clk);
    #3;
    check("retires_left", 32'(ret_q.size()), 32'h0);
    check("stores_left", 32'(st_q.size()), 32'h0);
    ret_q.delete();
    st_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // ALU sequence, zero wait
    clear_img(); wait_n = 0;
    img[0] = 32'h0e800093; img[1] = 32'h3e800113; img[2] = 32'h001101b3; img[3] = 32'h40110233;
    do_reset();
    exp_ret(4, 32'h4); exp_ret(8, 32'h8); exp_ret(12, 32'hC); exp_ret(16, 32'h10);
    run_until_halt(200);
    read_reg("alu_x1", 4'd1, 32'd232);
    read_reg("alu_x2", 4'd2, 32'd1000);
    read_reg("alu_x3", 4'd3, 32'd1232);
    read_reg("alu_x4", 4'd4, 32'd768);

    // Three wait states on every request
    clear_img(); wait_n = 3;
    img[0] = 32'h00500093;
    do_reset();
    exp_ret(7, 32'h4);
    run_until_halt(200);
    read_reg("wait_x1", 4'd1, 32'd5);

    // Store then sign-extending load through address 8
    clear_img(); wait_n = 0;
    img[0] = 32'hFF600093; img[1] = 32'h01C0006F; img[8] = 32'h00102423; img[9] = 32'h00802283;
    do_reset();
    exp_ret(4, 32'h4); exp_ret(7, 32'h20); exp_ret(11, 32'h24); exp_ret(16, 32'h28);
    st_q.push_back('{addr: 32'h8, data: 32'hFFFFFFF6});
    run_until_halt(200);
    read_reg("mem_x1", 4'd1, 32'hFFFFFFF6);
    read_reg("mem_x5", 4'd5, 32'hFFFFFFF6);
    read_reg("mem_x0", 4'd0, 32'h0);

    // Branch taken, branch not taken, jal forward, jal backward with link
    clear_img(); wait_n = 0;
    img[0] = 32'h0e800093; img[1] = 32'h01C0006F; img[8] = 32'h00000463;
    img[10] = 32'h00100463; img[11] = 32'h0140006F; img[16] = 32'hFF1FF0EF;
    do_reset();
    exp_ret(4, 32'h4); exp_ret(7, 32'h20); exp_ret(10, 32'h28);
    exp_ret(13, 32'h2C); exp_ret(16, 32'h40); exp_ret(19, 32'h30);
    run_until_halt(200);
    read_reg("jal_x1", 4'd1, 32'h44);

    // Illegal opcode: halt with pc frozen past the fetch
    clear_img(); wait_n = 0;
    img[0] = 32'h0000007F;
    do_reset();
    run_until_halt(50);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); #2;
      check("halt_mem_valid", 32'(mem_valid), 32'h0);
      check("halt_pc", pc, 32'h4);
      check("halt_illegal", 32'(illegal), 32'h1);
    end

    // Misaligned load address halts before any data request
    clear_img(); wait_n = 0;
    img[0] = 32'h00602283;
    do_reset();
    run_until_halt(50);
    check("mis_pc", pc, 32'h4);
    check("mis_mem_valid", 32'(mem_valid), 32'h0);
    read_reg("mis_x5", 4'd5, 32'h0);

    // Register index beyond NREGS=16 halts without writing
    clear_img(); wait_n = 0;
    img[0] = 32'h00500093; img[1] = 32'h002088B3;
    do_reset();
    exp_ret(4, 32'h4);
    run_until_halt(50);
    check("rv32e_pc", pc, 32'h8);
    read_reg("rv32e_x1", 4'd1, 32'd5);

    // Reset during a load wait, then rerun the same program to completion
    clear_img(); wait_n = 3;
    img[0] = 32'h00500093; img[1] = 32'h00802283; img[2] = 32'h00001234;
    do_reset();
    exp_ret(7, 32'h4);
    begin
      int unsigned n = 0;
      while (!(mem_valid === 1'b1 && mem_addr == 32'h8 && mem_we === 1'b0) && n < 100) begin
        @(negedge clk); #2; n++;
      end
      check("midwait_reached", 32'(mem_valid === 1'b1 && mem_addr == 32'h8), 32'h1);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #2;
    check("midrst_pc", pc, 32'h0);
    check("midrst_mem_valid", 32'(mem_valid), 32'h0);
    check("midrst_retire", 32'(retire), 32'h0);
    read_reg("midrst_x1", 4'd1, 32'h0);
    check("midrst_queue", 32'(ret_q.size()), 32'h0);
    exp_ret(7, 32'h4); exp_ret(18, 32'h8);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #2;
    check("restart_valid", 32'(mem_valid), 32'h1);
    check("restart_addr", mem_addr, 32'h0);
    run_until_halt(200);
    read_reg("restart_x1", 4'd1, 32'd5);
    read_reg("restart_x5", 4'd5, 32'h00001234);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
